pmem_responder: RTL and testbench

Memory-side responder for the core's physical-memory interface: it accepts one read or write request at a time over a valid/ready handshake, services it from an internal word-organised array after a fixed latency, and returns read data or a write acknowledgement. It replaces the zero-latency DPI memory path so the core's fetch/load/store logic can be exercised against a realistic multi-cycle slave.

---
 rtl/pmem_if.sv | 25 ++
 rtl/pmem_responder.sv | 192 +++++++++++++++++++
 tb/tb_pmem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pmem_if.sv
// Request/response bus between a memory requester (master) and a responder (slave).
// Valid/ready handshake on both the request and the response channel.
interface pmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_len;
    logic [31:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_len, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_len, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/pmem_responder.sv
// Multi-cycle physical-memory responder: one request at a time, fixed latency, word array.
// Define PMEM_RESP_RAND_DELAY_EN to add 0-3 LFSR-chosen extra busy cycles per request.
module pmem_responder #(
    parameter logic [31:0] BASE        = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 2
) (
    input  logic    clk,
    input  logic    reset,
    pmem_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 4);
    localparam logic [29:0] DEPTH_W30 = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] extra_delay;

    logic [31:0]   addr_reg;
    logic          wen_reg;
    logic [2:0]    len_reg;
    logic [31:0]   wdata_reg;
    logic [7:0]    wmask_reg;
    logic [31:0]   rdata_reg;
    logic          err_reg;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rd_word_reg;

    logic          req_ready_c;
    logic          resp_valid_c;
    logic          accept;
    logic          do_access;

    // ---------------------------------------------------------------- control
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        req_ready_c  = 1'b0;
        resp_valid_c = 1'b0;
        accept       = 1'b0;
        do_access    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = CW'(LATENCY - 1) + extra_delay;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                resp_valid_c = 1'b1;
                if (bus.resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PMEM_RESP_RAND_DELAY_EN
    logic [7:0] lfsr_reg;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so delays vary request to request.
    always_ff @(posedge clk) begin
        if (reset) lfsr_reg <= 8'hA5;
        else       lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end

    assign extra_delay = {{(CW-2){1'b0}}, lfsr_reg[1:0]};
`else
    assign extra_delay = '0;
`endif

    // ------------------------------------------------------------ request capture
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= '0;
            wen_reg   <= 1'b0;
            len_reg   <= '0;
            wdata_reg <= '0;
            wmask_reg <= '0;
        end else if (accept) begin
            addr_reg  <= bus.req_addr;
            wen_reg   <= bus.req_wen;
            len_reg   <= bus.req_len;
            wdata_reg <= bus.req_wdata;
            wmask_reg <= bus.req_wmask;
        end
    end

    // ------------------------------------------------------------ decode / checks
    logic [31:0]   cap_off;
    logic [1:0]    offset;
    logic [AW-1:0] cap_idx;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] rd_idx;
    logic [6:0]    lane_wide;
    logic [3:0]    lane_mask;
    logic          in_range;
    logic          rd_err;
    logic          wr_err;
    logic          acc_err;
    logic          mem_we;

    assign cap_off   = addr_reg - BASE;
    assign offset    = cap_off[1:0];
    assign cap_idx   = AW'(cap_off >> 2);
    assign req_idx   = AW'((bus.req_addr - BASE) >> 2);
    assign in_range  = (addr_reg >= BASE) && (cap_off[31:2] < DEPTH_W30);
    assign lane_wide = {3'b000, wmask_reg[3:0]} << offset;
    assign lane_mask = lane_wide[3:0];

    assign rd_err  = !((len_reg == 3'd1) || (len_reg == 3'd2) || (len_reg == 3'd4))
                   || ((len_reg == 3'd2) && offset[0])
                   || ((len_reg == 3'd4) && (offset != 2'd0));
    assign wr_err  = (|wmask_reg[7:4]) || (|lane_wide[6:4]);
    assign acc_err = !in_range || (wen_reg ? wr_err : rd_err);
    assign mem_we  = do_access && wen_reg && !acc_err && !reset;

    // Read port follows the live request address in IDLE so the word is ready even at LATENCY=1.
    assign rd_idx = (state_reg == IDLE) ? req_idx : cap_idx;

    // ------------------------------------------------------------------ array
    logic [31:0] wdata_shift;
    assign wdata_shift = wdata_reg << {offset, 3'b000};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) mem[cap_idx][i*8 +: 8] <= wdata_shift[i*8 +: 8];
            end
        end
        rd_word_reg <= mem[rd_idx];
    end

    // ------------------------------------------------------------- read align
    logic [31:0] rd_shift;
    logic [31:0] rdata_sel;
    logic [3:0]  keep_bytes;

    assign rd_shift = rd_word_reg >> {offset, 3'b000};

    always_comb begin
        case (len_reg)
            3'd1:    keep_bytes = 4'b0001;
            3'd2:    keep_bytes = 4'b0011;
            default: keep_bytes = 4'b1111;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
            assign rdata_sel[gi*8 +: 8] = keep_bytes[gi] ? rd_shift[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (do_access) begin
            rdata_reg <= (acc_err || wen_reg) ? 32'h0 : rdata_sel;
            err_reg   <= acc_err;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.resp_rdata = rdata_reg;
    assign bus.resp_err   = err_reg;
endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: driver queues expected responses, monitor checks them.
module tb_pmem_responder;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pmem_if bus();

    pmem_responder #(
        .BASE(32'h8000_0000),
        .DEPTH_WORDS(4096),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   txn_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: latency on rising resp_valid, data/err on each response handshake.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.resp_valid && !prev_valid && sb_q.size() > 0) begin
`ifdef PMEM_RESP_RAND_DELAY_EN
                check("latency_range", 32'((cyc - sb_q[0].acc_cyc >= LAT) && (cyc - sb_q[0].acc_cyc <= LAT + 3)), 32'd1);
`else
                check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(LAT));
`endif
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got rdata %h err %b, required no response", bus.resp_rdata, bus.resp_err);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    $display("txn %0d: rdata=%h err=%b (expect %h/%b)", e.id, bus.resp_rdata, bus.resp_err, e.rdata, e.err);
                    check($sformatf("txn%0d_rdata", e.id), bus.resp_rdata, e.rdata);
                    check($sformatf("txn%0d_err", e.id), 32'(bus.resp_err), 32'(e.err));
                end
            end
            prev_valid = bus.resp_valid;
        end
    end

    task automatic drive(input logic [31:0] addr, input logic wen, input logic [2:0] len,
                         input logic [31:0] wdata, input logic [7:0] wmask);
        bus.req_addr  = addr;
        bus.req_wen   = wen;
        bus.req_len   = len;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
        bus.req_valid = 1'b1;
    endtask

    task automatic wait_ready(output bit ok);
        int t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = bus.req_ready;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got 0 required 1");
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic wen, input logic [2:0] len,
                          input logic [31:0] wdata, input logic [7:0] wmask,
                          input logic [31:0] exp_rdata, input logic exp_err);
        bit ok;
        exp_t e;
        wait_ready(ok);
        if (ok) begin
            drive(addr, wen, len, wdata, wmask);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            txn_id++;
            e.rdata   = exp_rdata;
            e.err     = exp_err;
            e.acc_cyc = cyc;
            e.id      = txn_id;
            sb_q.push_back(e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        bit ok;
        int t;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wen    = 1'b0;
        bus.req_len    = '0;
        bus.req_wdata  = '0;
        bus.req_wmask  = '0;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", 32'(bus.req_ready), 32'd1);
        check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset_rdata", bus.resp_rdata, 32'h0);
        check("reset_err", 32'(bus.resp_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        //     addr           wen   len   wdata          wmask   exp_rdata      err
        do_req(32'h8000_0000, 1'b1, 3'd4, 32'hDEAD_BEEF, 8'h0F, 32'h0000_0000, 1'b0);
        do_req(32'h8000_0000, 1'b0, 3'd4, 32'h0,         8'h00, 32'hDEAD_BEEF, 1'b0);
        do_req(32'h8000_0003, 1'b1, 3'd1, 32'h0000_00AB, 8'h01, 32'h0000_0000, 1'b0);
        do_req(32'h8000_0000, 1'b0, 3'd4, 32'h0,         8'h00, 32'hABAD_BEEF, 1'b0);
        do_req(32'h8000_0003, 1'b0, 3'd1, 32'h0,         8'h00, 32'h0000_00AB, 1'b0);
        do_req(32'h8000_0001, 1'b0, 3'd1, 32'h0,         8'h00, 32'h0000_00BE, 1'b0);
        do_req(32'h8000_0002, 1'b0, 3'd2, 32'h0,         8'h00, 32'h0000_ABAD, 1'b0);
        do_req(32'h8000_0001, 1'b0, 3'd4, 32'h0,         8'h00, 32'h0000_0000, 1'b1);
        do_req(32'h8000_0001, 1'b0, 3'd2, 32'h0,         8'h00, 32'h0000_0000, 1'b1);
        do_req(32'h8000_0000, 1'b0, 3'd3, 32'h0,         8'h00, 32'h0000_0000, 1'b1);
        do_req(32'h8000_0002, 1'b1, 3'd4, 32'h1111_1111, 8'h0F, 32'h0000_0000, 1'b1);
        do_req(32'h8000_0000, 1'b1, 3'd4, 32'h2222_2222, 8'h10, 32'h0000_0000, 1'b1);
        do_req(32'h8000_0000, 1'b0, 3'd4, 32'h0,         8'h00, 32'hABAD_BEEF, 1'b0);
        do_req(32'h7FFF_FFFC, 1'b0, 3'd4, 32'h0,         8'h00, 32'h0000_0000, 1'b1);
        do_req(32'h8000_4000, 1'b0, 3'd4, 32'h0,         8'h00, 32'h0000_0000, 1'b1);
        do_req(32'h8000_3FFC, 1'b1, 3'd0, 32'h5566_7788, 8'h0C, 32'h0000_0000, 1'b0);
        do_req(32'h8000_3FFE, 1'b0, 3'd2, 32'h0,         8'h00, 32'h0000_5566, 1'b0);
        do_req(32'h8000_0010, 1'b1, 3'd4, 32'hCAFE_F00D, 8'h0F, 32'h0000_0000, 1'b0);
        do_req(32'h8000_0010, 1'b0, 3'd4, 32'h0,         8'h00, 32'hCAFE_F00D, 1'b0);
        drain();

        // Stall in RESP: outputs must hold while resp_ready is low.
        bus.resp_ready = 1'b0;
        do_req(32'h8000_0000, 1'b0, 3'd4, 32'h0, 8'h00, 32'hABAD_BEEF, 1'b0);
        t = 0;
        while (!bus.resp_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall%0d_valid", i), 32'(bus.resp_valid), 32'd1);
            check($sformatf("stall%0d_rdata", i), bus.resp_rdata, 32'hABAD_BEEF);
            check($sformatf("stall%0d_req_ready", i), 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_stall_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_stall_resp_valid", 32'(bus.resp_valid), 32'd0);
        drain();

        // Reset while BUSY abandons the write.
        wait_ready(ok);
        if (ok) begin
            drive(32'h8000_0010, 1'b1, 3'd4, 32'h1234_5678, 8'h0F);
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
            @(negedge clk);
            check("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
            check("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        do_req(32'h8000_0010, 1'b0, 3'd4, 32'h0, 8'h00, 32'hCAFE_F00D, 1'b0);
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
